// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 Pmod keypad column scanner with frame-level debounce.
// Emits the accepted hex key as a one-cycle valid pulse plus a held-level flag.
module keypad_scanner #(
    parameter int SCAN_BITS      = 17,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] o_col_n,
    input  logic [3:0] i_row_n,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_down
);
    localparam logic [3:0]  DEB   = 4'(DEBOUNCE_SCANS);
    // Hex code for key index 4*column+row, index 0 in the low nibble.
    localparam logic [63:0] CODES = {4'hD, 4'hC, 4'hB, 4'hA, 4'hE, 4'h9, 4'h6, 4'h3,
                                     4'hF, 4'h8, 4'h5, 4'h2, 4'h0, 4'h7, 4'h4, 4'h1};

    logic [3:0]           r_sync1, r_sync2;
    logic [SCAN_BITS-1:0] r_cnt;
    logic [1:0]           r_col;
    logic [11:0]          r_hits;
    logic                 r_cand_v;
    logic [3:0]           r_cand_c, r_count;
    logic                 w_step, w_frame_end, w_res_v, w_same, w_acc;
    logic [3:0]           w_res_c, w_next_cnt;
    logic [15:0]          w_all;

    assign w_step      = &r_cnt;
    assign w_frame_end = w_step && (r_col == 2'd3);
    assign w_all       = {~r_sync2, r_hits};

    // Descending scan so the lowest column/row index wins.
    always_comb begin
        w_res_v = 1'b0;
        w_res_c = 4'h0;
        for (int i = 15; i >= 0; i--)
            if (w_all[i]) begin
                w_res_v = 1'b1;
                w_res_c = CODES[4*i +: 4];
            end
    end

    assign w_same     = (w_res_v == r_cand_v) && (!w_res_v || w_res_c == r_cand_c);
    assign w_next_cnt = !w_same ? 4'd1 : (r_count == DEB ? DEB : r_count + 4'd1);
    assign w_acc      = w_frame_end && (w_next_cnt == DEB) && !(w_same && r_count == DEB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 4'b1111;
            r_sync2     <= 4'b1111;
            r_cnt       <= '0;
            r_col       <= 2'd0;
            r_hits      <= '0;
            r_cand_v    <= 1'b0;
            r_cand_c    <= 4'h0;
            r_count     <= 4'd0;
            o_col_n     <= 4'b1110;
            o_key_code  <= 4'h0;
            o_key_valid <= 1'b0;
            o_key_down  <= 1'b0;
        end else begin
            r_sync1     <= i_row_n;
            r_sync2     <= r_sync1;
            r_cnt       <= r_cnt + 1'b1;
            o_key_valid <= 1'b0;
            if (w_step) begin
                r_col   <= r_col + 2'd1;
                o_col_n <= {o_col_n[2:0], o_col_n[3]};
                if (r_col != 2'd3)
                    r_hits[{r_col, 2'b00} +: 4] <= ~r_sync2;
            end
            if (w_frame_end) begin
                r_cand_v <= w_res_v;
                r_cand_c <= w_res_c;
                r_count  <= w_next_cnt;
            end
            if (w_acc) begin
                if (!w_res_v)
                    o_key_down <= 1'b0;
                else if (!o_key_down || w_res_c != o_key_code) begin
                    o_key_code  <= w_res_c;
                    o_key_down  <= 1'b1;
                    o_key_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus pulse scoreboard for keypad_scanner.
// Dwell is 4 clocks, so frame f ends on the clock cycle numbered 16*f after reset release.
module tb_keypad_scanner;
    localparam int K1 = 0, K0 = 3, K5 = 5, K9 = 10, KD = 15;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col_n, row_n, key_code;
    logic        key_valid, key_down;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    keypad_scanner #(.SCAN_BITS(2), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst(rst), .o_col_n(col_n), .i_row_n(row_n),
        .o_key_code(key_code), .o_key_valid(key_valid), .o_key_down(key_down)
    );

    always #5 clk = ~clk;

    // Each pressed key shorts its row low while its column strobe is low.
    always_comb begin
        row_n = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[4*c+r] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: key_code=%h at cycle %0d, no pulse required", key_code, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (key_code !== e.code || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got code %h at cycle %0d, required code %h at cycle %0d", key_code, cyc, e.code, e.cyc);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] cols [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        pressed = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_assert++;
        if ({col_n, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: col_n=%b code=%h valid=%b down=%b, required 1110 0 0 0", col_n, key_code, key_valid, key_down);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_cyc(3);
        n_assert++;
        if (col_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL col_before_step: col_n=%b, required 1110", col_n);
        end
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(4 * k);
            n_assert++;
            if (col_n !== cols[k]) begin
                n_fail++;
                $display("FAIL col_rotate%0d: col_n=%b, required %b", k, col_n, cols[k]);
            end
        end
        wait_cyc(160);
        n_assert++;
        if (key_code !== 4'h0 || key_down !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL idle: code=%h down=%b pending=%0d, required 0 0 0", key_code, key_down, sb.size());
        end
    endtask

    task automatic test_press_hold();
        pressed = 16'(1) << K5;
        sb.push_back('{4'h5, 48});
        apply_reset();
        wait_cyc(47);
        n_assert++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL down_early: key_down=%b at cycle 47, required 0", key_down);
        end
        wait_cyc(50);
        n_assert++;
        if (key_code !== 4'h5 || key_down !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL press5: code=%h down=%b pending=%0d, required 5 1 0", key_code, key_down, sb.size());
        end
        wait_cyc(208);
        n_assert++;
        if (key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL hold5: key_down=%b, required 1", key_down);
        end
    endtask

    task automatic test_release();
        pressed = '0;
        wait_cyc(255);
        n_assert++;
        if (key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL release_early: key_down=%b at cycle 255, required 1", key_down);
        end
        wait_cyc(256);
        n_assert++;
        if (key_down !== 1'b0 || key_code !== 4'h5) begin
            n_fail++;
            $display("FAIL release: down=%b code=%h, required 0 5", key_down, key_code);
        end
    endtask

    task automatic test_bounce();
        pressed = 16'(1) << K9;
        wait_cyc(272);
        pressed = '0;
        wait_cyc(288);
        pressed = 16'(1) << K9;
        sb.push_back('{4'h9, 336});
        wait_cyc(335);
        n_assert++;
        if (key_down !== 1'b0 || sb.size() != 1) begin
            n_fail++;
            $display("FAIL bounce_early: down=%b pending=%0d, required 0 1", key_down, sb.size());
        end
        wait_cyc(340);
        n_assert++;
        if (key_code !== 4'h9 || key_down !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bounce9: code=%h down=%b pending=%0d, required 9 1 0", key_code, key_down, sb.size());
        end
    endtask

    task automatic test_two_keys();
        pressed = (16'(1) << K1) | (16'(1) << KD);
        sb.push_back('{4'h1, 48});
        sb.push_back('{4'hD, 112});
        apply_reset();
        wait_cyc(50);
        n_assert++;
        if (key_code !== 4'h1 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL priority: code=%h down=%b, required 1 1", key_code, key_down);
        end
        wait_cyc(64);
        pressed = 16'(1) << KD;
        wait_cyc(111);
        n_assert++;
        if (key_code !== 4'h1 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL roll_early: code=%h down=%b, required 1 1", key_code, key_down);
        end
        wait_cyc(112);
        n_assert++;
        if (key_code !== 4'hD || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL roll_D: code=%h down=%b, required d 1", key_code, key_down);
        end
        wait_cyc(130);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL roll_pending: %0d pulses missing, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        pressed = 16'(1) << K0;
        apply_reset();
        sb.push_back('{4'h0, 48});
        wait_cyc(56);
        n_assert++;
        if (col_n !== 4'b1011 || key_down !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL hold0: col_n=%b down=%b pending=%0d, required 1011 1 0", col_n, key_down, sb.size());
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if (col_n !== 4'b1110 || key_down !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: col_n=%b down=%b valid=%b, required 1110 0 0", col_n, key_down, key_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{4'h0, 48});
        wait_cyc(47);
        n_assert++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL redebounce_early: key_down=%b, required 0", key_down);
        end
        wait_cyc(52);
        n_assert++;
        if (key_code !== 4'h0 || key_down !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL redebounce: code=%h down=%b pending=%0d, required 0 1 0", key_code, key_down, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_press_hold();
        test_release();
        test_bounce();
        test_two_keys();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active scanner for the 4x4 Pmod keypad. Drives the column strobes and reads the row returns.
- Debounces the scan result over several full scan frames.
- Emits a 4-bit hex key code with a one-cycle valid pulse and a held-level flag.
- Sits between the Pmod pins and the display/application logic. Uses an internal free-running dwell counter to time column steps.

Parameters:
- SCAN_BITS, 17: dwell counter width; each column is driven for 2**SCAN_BITS clocks.
- DEBOUNCE_SCANS, 3: consecutive identical frames required to accept a press or a release (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- col_n  output  4  column strobes, active-low, exactly one bit low at a time
- row_n  input  4  row returns, active-low (pulled up off-chip), asynchronous to clk
- key_code  output  4  hex code of the accepted key
- key_valid  output  1  one-cycle pulse when a new key_code is accepted
- key_down  output  1  high while an accepted key is held

Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset values (asynchronous, immediate): col_n=4'b1110 (column 0 active), key_code=0, key_valid=0, key_down=0, dwell counter=0, frame hit registers cleared, debounce candidate=none, count=0.
  - Synchronizer flops reset to 4'b1111.
- Row input: row_n passes through a 2-flop synchronizer; all sampling uses the synced value.
- Dwell counter:
  - Increments every clk and wraps.
  - Step event: the cycle where counter == 2**SCAN_BITS-1.
  - On a step event, sample the synced rows for the active column, then rotate col_n left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- Frame:
  - Consists of four step events, columns 0..3.
  - The frame result is computed on the column-3 step event from the column 0..2 samples plus the column-3 sample.
- Multiple keys: priority goes to lowest column, then lowest row. Frame result is that key, or "none".
- Code map (column c, row r, rows 0..3):
  - c0: 1,4,7,0
  - c1: 2,5,8,F
  - c2: 3,6,9,E
  - c3: A,B,C,D
- Debounce, at each frame end:
  - Result == candidate: count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate <= result, count <= 1.
- Acceptance fires on the frame end where count first reaches DEBOUNCE_SCANS. With DEBOUNCE_SCANS=1, every candidate change accepts immediately.
  - Candidate is a key and (key_down==0 or key differs from key_code): key_code <= key, key_down <= 1, key_valid=1 for exactly one cycle, on the cycle after the frame-end step event.
  - Candidate is a key identical to the held key_code: no change.
  - Candidate is none: key_down <= 0, key_code holds its last value, no pulse.
- Held key: at most one key_valid per press.
  - Rolling from key X to key Y without an accepted release pulses once for Y.
- Latency: a stable press produces key_valid within (DEBOUNCE_SCANS+1) frames + 3 clocks. One frame = 4*2**SCAN_BITS clocks.
- rst asserted mid-scan or mid-debounce: everything returns to reset values at once. A key still held after release of rst must be debounced again from zero and pulses again.
- key_valid and key_down are registered outputs; no combinational path from row_n.

Test Plan (sim parameters SCAN_BITS=2 => 4-clock dwell, 16-clock frame, DEBOUNCE_SCANS=3; keypad model pulls row r low while col_n[c]==0 for each pressed key):
- Reset, no keys -> col_n=1110 during reset; 1101 after 4 clocks, 1011 after 8, 0111 after 12, 1110 after 16; key_valid, key_down, key_code stay 0 for 10 frames.
- Press '5' (c1,r1) from reset and hold -> exactly one key_valid pulse, at the end of the 3rd full frame containing the press; key_code=4'h5, key_down=1; no further pulses over 10 more frames.
- Release after an accepted '5' -> key_down falls after 3 empty frames; key_valid stays 0; key_code stays 5.
- Bounce pattern press/release/press, one frame each, then hold '9' -> no pulse until 3 consecutive '9' frames; then one pulse with key_code=4'h9.
- Hold '1' (c0,r0) and 'D' (c3,r3) together -> key_code=4'h1, one pulse. Then release '1' while keeping 'D' -> after 3 frames key_code=4'hD, one more pulse, key_down stays 1.
- Hold '0' until accepted, pulse rst for 2 clocks mid-frame -> col_n=1110 and key_down=0 immediately; while still held, a new single pulse with key_code=4'h0 after 3 frames.
